// File: rtl/bounce_pkg.sv
// Shared definitions for the button bounce emulator: state encoding, LFSR taps,
// default settle time and a counter-width helper.
package bounce_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BOUNCE_A = 2'd1,
    BOUNCE_B = 2'd2,
    SETTLE   = 2'd3
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned SETTLE_CYC_DEF = 64;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/button_bounce_gen_if.sv
// Command channel into the bounce emulator. A command transfers on a rising clk
// edge where cmd_valid && cmd_ready; cmd_ready is high only while idle.
interface button_bounce_gen_if;
  logic cmd_valid;
  logic cmd_level;
  logic cmd_ready;

  modport master (output cmd_valid, output cmd_level, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_level, output cmd_ready);
endinterface

// File: rtl/button_bounce_gen_lfsr16.sv
// 16-bit Fibonacci LFSR, free running, async active-low reset to SEED.
// A zero seed would lock up, so it is replaced by 16'h0001.
module lfsr16
  import bounce_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED_EFF;
    else        q <= {q[14:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/button_bounce_gen.sv
// Bounce emulator: turns a clean level command into a glitch burst plus settle.
// Define BOUNCE_FIXED_EN for deterministic timing (n = CNT_MASK, gap = MIN_GAP).
module button_bounce_gen
  import bounce_pkg::*;
#(
  parameter int unsigned CNT_MASK   = 7,
  parameter int unsigned MIN_GAP    = 2,
  parameter int unsigned GAP_MASK   = 15,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_bounce_gen_if.slave   cmd,
  output logic                 btn_out,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           glitch_cnt,
  output state_t               dbg_state
);

  localparam int unsigned CNT_W = cnt_width(MIN_GAP + GAP_MASK, SETTLE_CYC);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC);

  state_t           state;
  logic             tgt;
  logic             old;
  logic [3:0]       n_q;
  logic [CNT_W-1:0] cnt;
  logic             cmd_ready_q;
  logic [15:0]      lfsr;
  logic [3:0]       n_pick;
  logic [CNT_W-1:0] gap_pick;
  logic             unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

`ifdef BOUNCE_FIXED_EN
  assign n_pick   = 4'(CNT_MASK);
  assign gap_pick = CNT_W'(MIN_GAP);
`else
  assign n_pick   = lfsr[3:0] & 4'(CNT_MASK);
  assign gap_pick = CNT_W'(MIN_GAP) + CNT_W'(lfsr[7:4] & 4'(GAP_MASK));
`endif

  assign unused_lfsr   = ^lfsr;
  assign cmd.cmd_ready = cmd_ready_q;
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tgt         <= 1'b0;
      old         <= 1'b0;
      n_q         <= 4'd0;
      cnt         <= '0;
      btn_out     <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      glitch_cnt  <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd.cmd_valid && cmd_ready_q) begin
            tgt         <= cmd.cmd_level;
            old         <= btn_out;
            n_q         <= n_pick;
            glitch_cnt  <= 4'd0;
            cmd_ready_q <= 1'b0;
            busy        <= 1'b1;
            if (cmd.cmd_level == btn_out) begin
              state <= SETTLE;
              cnt   <= SETTLE_LOAD;
            end else if (n_pick == 4'd0) begin
              btn_out <= cmd.cmd_level;
              state   <= SETTLE;
              cnt     <= SETTLE_LOAD;
            end else begin
              btn_out <= cmd.cmd_level;
              state   <= BOUNCE_A;
              cnt     <= gap_pick;
            end
          end
        end
        BOUNCE_A: begin
          if (cnt == ONE) begin
            btn_out <= old;
            cnt     <= gap_pick;
            state   <= BOUNCE_B;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        BOUNCE_B: begin
          if (cnt == ONE) begin
            glitch_cnt <= (glitch_cnt == 4'hF) ? 4'hF : glitch_cnt + 4'd1;
            btn_out    <= tgt;
            // Burst ends once the glitch being completed is the n-th one.
            if (({1'b0, glitch_cnt} + 5'd1) == {1'b0, n_q}) begin
              state <= SETTLE;
              cnt   <= SETTLE_LOAD;
            end else begin
              state <= BOUNCE_A;
              cnt   <= gap_pick;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        SETTLE: begin
          if (cnt == ONE) begin
            state       <= IDLE;
            done        <= 1'b1;
            busy        <= 1'b0;
            cmd_ready_q <= 1'b1;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_bounce_gen.sv
// Bench for button_bounce_gen: a waveform model predicts each cycle of every
// transition as a list of level runs computed from an arithmetic LFSR model.
module tb_button_bounce_gen;
  import bounce_pkg::*;

  localparam int unsigned CNT_MASK   = 3;
  localparam int unsigned MIN_GAP    = 2;
  localparam int unsigned GAP_MASK   = 15;
  localparam int unsigned SETTLE_CYC = 8;
  localparam logic [15:0] SEED       = 16'hACE1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_out, busy, done;
  logic [3:0] glitch_cnt;
  state_t     dbg_state;

  button_bounce_gen_if cmd_bus ();

  button_bounce_gen #(
    .CNT_MASK   (CNT_MASK),
    .MIN_GAP    (MIN_GAP),
    .GAP_MASK   (GAP_MASK),
    .SETTLE_CYC (SETTLE_CYC),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd_bus.slave),
    .btn_out    (btn_out),
    .busy       (busy),
    .done       (done),
    .glitch_cnt (glitch_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // scoreboard: per-cycle {cmd_ready, busy, done, btn_out}
  logic [3:0]  exp_q[$];
  logic        exp_btn = 1'b0;
  logic [15:0] m_lfsr  = SEED;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int unsigned v, fb;
    v  = s;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'(((v << 1) | fb) & 32'hFFFF);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr = SEED;
    else        m_lfsr = lfsr_next(m_lfsr);
  end

  function automatic int glitches_for(input logic [15:0] s);
`ifdef BOUNCE_FIXED_EN
    return CNT_MASK;
`else
    return (int'(s) % 16) & CNT_MASK;
`endif
  endfunction

  function automatic int gap_for(input logic [15:0] s);
`ifdef BOUNCE_FIXED_EN
    return MIN_GAP;
`else
    return MIN_GAP + (((int'(s) / 16) % 16) & GAP_MASK);
`endif
  endfunction

  // Expected waveform: n pairs of (tgt for gap, old for gap), settle, done, idle.
  // A gap is drawn from the LFSR value of the cycle in which the previous run ends.
  task automatic build_expected(input logic old, input logic tgt, input logic [15:0] s0,
                                output int n, output int first_b);
    logic [15:0] s;
    int t, g;
    s = s0; t = 0; first_b = 0;
    exp_q.delete();
    n = (old == tgt) ? 0 : glitches_for(s0);
    for (int k = 0; k < n; k++) begin
      g = gap_for(s);
      for (int j = 0; j < g; j++) begin exp_q.push_back({3'b010, tgt}); s = lfsr_next(s); end
      t += g;
      if (k == 0) first_b = t + 1;
      g = gap_for(s);
      for (int j = 0; j < g; j++) begin exp_q.push_back({3'b010, old}); s = lfsr_next(s); end
      t += g;
    end
    for (int j = 0; j < SETTLE_CYC; j++) exp_q.push_back({3'b010, tgt});
    exp_q.push_back({3'b101, tgt});
    exp_q.push_back({3'b100, tgt});
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (btn_out !== 1'b0) begin
      errors++; $display("FAIL mid_reset_btn: got %b expected 0", btn_out);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL mid_reset_done: got %b expected 0", done);
      end
    end
    rst_n = 1'b1;
    checks++;
    if ({dbg_state, cmd_bus.cmd_ready, busy, glitch_cnt, btn_out} !== {IDLE, 1'b1, 1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL after_mid_reset: got state=%0d ready=%b busy=%b gcnt=%0d btn=%b expected 0 1 0 0 0",
               dbg_state, cmd_bus.cmd_ready, busy, glitch_cnt, btn_out);
    end
    exp_btn = 1'b0;
  endtask

  // driver: issue one command at the current negedge and follow it to idle
  task automatic run_cmd(input logic level, input int poke_at, input bit abort_in_b);
    int n, first_b, i;
    bit aborted;
    logic [3:0] e, obs;
    aborted = 1'b0;
    checks++;
    if (cmd_bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ready_before_cmd: got %b expected 1", cmd_bus.cmd_ready);
    end
    build_expected(exp_btn, level, m_lfsr, n, first_b);
    cmd_bus.cmd_level = level;
    cmd_bus.cmd_valid = 1'b1;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      i++;
      cmd_bus.cmd_valid = (i == poke_at);
      cmd_bus.cmd_level = (i == poke_at) ? ~level : level;
      e   = exp_q.pop_front();
      obs = {cmd_bus.cmd_ready, busy, done, btn_out};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL step %0d (level=%b): got ready,busy,done,btn=%b expected %b", i, level, obs, e);
      end
      if (i == 1) begin
        checks++;
        if (glitch_cnt !== 4'd0) begin
          errors++; $display("FAIL glitch_clear: got %0d expected 0", glitch_cnt);
        end
      end
      if (e[1]) begin
        checks++;
        if (glitch_cnt !== 4'(n) || glitch_cnt > CNT_MASK) begin
          errors++; $display("FAIL glitch_cnt: got %0d expected %0d", glitch_cnt, n);
        end
      end
      if (abort_in_b && i == first_b) begin
        mid_reset();
        exp_q.delete();
        aborted = 1'b1;
      end
    end
    cmd_bus.cmd_valid = 1'b0;
    if (!aborted) exp_btn = level;
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    checks++;
    if ({btn_out, cmd_bus.cmd_ready, busy, done, glitch_cnt} !== {4'b0100, 4'd0}) begin
      errors++;
      $display("FAIL reset_state: got btn=%b ready=%b busy=%b done=%b gcnt=%0d expected 0 1 0 0 0",
               btn_out, cmd_bus.cmd_ready, busy, done, glitch_cnt);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++; $display("FAIL reset_fsm: got %0d expected 0", dbg_state);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_same_level();
    run_cmd(1'b0, 0, 1'b0);
  endtask

  task automatic test_transition();
    run_cmd(1'b1, 0, 1'b0);
    run_cmd(1'b1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_cmd(1'b0, 0, 1'b0);
    run_cmd(1'b1, 0, 1'b0);
    run_cmd(1'b0, 0, 1'b0);
  endtask

  task automatic test_ignore_busy();
    run_cmd(1'b1, 1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, btn_out, cmd_bus.cmd_ready} !== 3'b011) begin
        errors++;
        $display("FAIL ignore_busy_idle: got busy,btn,ready=%b expected 011", {busy, btn_out, cmd_bus.cmd_ready});
      end
    end
  endtask

  task automatic test_reset_mid_bounce();
    int tries;
    tries = 0;
    while (glitches_for(m_lfsr) == 0 && tries < 64) begin
      @(negedge clk);
      tries++;
    end
    checks++;
    if (tries >= 64) begin
      errors++; $display("FAIL reset_mid_wait: got no glitching slot in %0d cycles expected one", tries);
    end else begin
      run_cmd(1'b0, 0, 1'b1);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_cmd(~exp_btn, int'($urandom_range(0, 2)), 1'b0);
    end
  endtask

  initial begin
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_level = 1'b0;
    test_reset();
    test_same_level();
    test_transition();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_bounce();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_bounce_gen.md
Name: button_bounce_gen

Overview:
Synthesizable bounce emulator that drives a button-style line into debounce_module, the sending end of the btn interface. It takes a clean target level over a valid/ready handshake and produces a mechanically realistic transition. The transition is a burst of glitches with pseudo-random spacing, followed by a stable settle period. It is used for board self-test and for closed-loop verification of the debouncer without a physical switch.

Parameters:
CNT_MASK, 7, mask applied to LFSR bits for glitch count per transition (0..CNT_MASK glitches)
MIN_GAP, 2, minimum cycles per glitch half-period (>=1)
GAP_MASK, 15, mask applied to LFSR bits added to MIN_GAP for each half-period
SETTLE_CYC, 64, cycles the final level is held before done
LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR (0 is illegal and is forced to 16'h0001)

Ports:
clk        input   1   system clock
rst_n      input   1   asynchronous active-low reset
cmd_valid  input   1   request a transition to cmd_level
cmd_level  input   1   target clean level
cmd_ready  output  1   high when a command can be accepted (IDLE)
btn_out    output  1   bouncy button line to the debouncer
busy       output  1   high while in BOUNCE_A, BOUNCE_B or SETTLE
done       output  1   one-cycle pulse when settle completes
glitch_cnt output  4   glitches emitted in the last/current transition

Behaviour:
- One clock: clk. Reset rst_n is asynchronous, active-low. All flops clear asynchronously on rst_n low.
- Reset values: btn_out=0, cmd_ready=1, busy=0, done=0, glitch_cnt=0, state=IDLE, LFSR=LFSR_SEED (or 1 if the seed is 0).
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle whenever not in reset, independent of state.
- Handshake: a command is accepted on a rising clk with cmd_valid&&cmd_ready. cmd_ready=1 only in IDLE. cmd_valid while busy is ignored (not queued).
- On accept, latch tgt=cmd_level, old=btn_out, n=LFSR[3:0]&CNT_MASK, and clear glitch_cnt. Then:
  - If tgt==old: go directly to SETTLE with no toggles. btn_out stays unchanged.
  - Else if n==0: btn_out<=tgt next cycle, then SETTLE.
  - Else: go to BOUNCE_A.
- Gap load: each half-period loads gap = MIN_GAP + (LFSR[7:4]&GAP_MASK) from the LFSR value at the cycle of load. gap width is sized to hold MIN_GAP+GAP_MASK.
- BOUNCE_A: btn_out=tgt for gap cycles. Then btn_out<=old, reload gap, go to BOUNCE_B.
- BOUNCE_B: btn_out=old for gap cycles. Then glitch_cnt++.
  - If glitch_cnt+1==n: btn_out<=tgt, go to SETTLE.
  - Else: reload gap, btn_out<=tgt, go to BOUNCE_A.
- SETTLE: btn_out=tgt constant for SETTLE_CYC cycles. Then done=1 for exactly one cycle and return to IDLE. cmd_ready rises in the same cycle as done.
- btn_out comes directly from a flop; it is glitch-free at the clk level.
- Reset mid-operation: btn_out drops to 0 immediately. No done pulse. The LFSR reseeds.
- glitch_cnt saturates at 15. It holds its value in IDLE until the next accept.

Optional Feature:
- Macro: BOUNCE_FIXED_EN.
- Defined: the LFSR is bypassed for all timing decisions.
  - n = CNT_MASK.
  - Every half-period gap = MIN_GAP.
  - The waveform is fully deterministic for directed tests.
- Undefined: pseudo-random timing as above. The LFSR still exists in both builds.

Decomposition:
- Shared package bounce_pkg holds:
  - the state encoding constants (IDLE=0, BOUNCE_A=1, BOUNCE_B=2, SETTLE=3);
  - the LFSR tap mask;
  - the default SETTLE_CYC.
- One natural sub-module, lfsr16: 16-bit LFSR with asynchronous active-low reset, seed parameter and zero-seed guard. It is reusable by other stimulus blocks.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles -> btn_out=0, cmd_ready=1, busy=0, done=0, glitch_cnt=0.
- FIXED_EN, CNT_MASK=3, MIN_GAP=2, SETTLE_CYC=8; cmd_level=1 from idle 0 -> btn_out pattern 1,1,0,0 repeated 3 times, then 1 for 8 cycles. After that: done pulse of 1 cycle, glitch_cnt=3, cmd_ready=1.
- Same-level command (cmd_level=0 while btn_out=0) -> no toggles, busy for SETTLE_CYC cycles, then done.
- cmd_valid pulsed with cmd_level=0 during BOUNCE_A -> ignored. After done, btn_out=1 and no second transition occurs.
- rst_n asserted mid-BOUNCE_B -> btn_out=0 within the same cycle, no done, state IDLE after release.
- Random mode, 200 alternating commands into debounce_module -> debounce output matches each cmd_level after settle. Every glitch_cnt<=CNT_MASK and every half-period lies in MIN_GAP..MIN_GAP+GAP_MASK.
